// File: rtl/ascon_rc_pkg.sv
// Shared encodings and helpers for the Ascon round-constant sequencer.
package ascon_rc_pkg;

   localparam logic [1:0] MODE_PA12    = 2'b00;
   localparam logic [1:0] MODE_PB8     = 2'b01;
   localparam logic [1:0] MODE_PB6     = 2'b10;
   localparam logic [1:0] MODE_ILLEGAL = 2'b11;

   localparam logic [3:0] ROUNDS_MAX = 4'd12;

   typedef enum logic {IDLE, RUN} state_t;

   function automatic logic [3:0] rounds_of(input logic [1:0] mode);
      case (mode)
         MODE_PA12: rounds_of = 4'd12;
         MODE_PB8:  rounds_of = 4'd8;
         MODE_PB6:  rounds_of = 4'd6;
         default:   rounds_of = 4'd0;
      endcase
   endfunction

   function automatic logic [7:0] rc_of(input logic [3:0] r);
      rc_of = {4'(4'd15 - r), r};
   endfunction

endpackage

// File: rtl/ascon_rc_seq.sv
// Ascon round-constant sequencer: emits UNROLL constants per advance for
// the tail of the 12-round schedule selected by mode.
module ascon_rc_seq
   import ascon_rc_pkg::*;
#(
   parameter int UNROLL = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic                  advance,
   input  logic                  abort,
   output logic [8*UNROLL-1:0]   rc,
   output logic                  rc_valid,
   output logic                  last,
   output logic [3:0]            round_idx,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   generate
      if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
         $error("ascon_rc_seq: UNROLL must be 1 or 2");
      end
   endgenerate

   state_t              state, state_n;
   logic [3:0]          r_n;
   logic                vld_n, last_n, done_n, err_n;
   logic [8*UNROLL-1:0] rc_n;

   always_comb begin
      state_n = state;
      r_n     = round_idx;
      vld_n   = rc_valid;
      done_n  = 1'b0;
      err_n   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (mode == MODE_ILLEGAL) begin
                  err_n = 1'b1;
               end else begin
                  state_n = RUN;
                  r_n     = ROUNDS_MAX - rounds_of(mode);
                  vld_n   = 1'b1;
               end
            end
         end
         RUN: begin
            // abort wins over advance, even on the final word
            if (abort) begin
               state_n = IDLE;
               r_n     = 4'd0;
               vld_n   = 1'b0;
            end else if (advance) begin
               if (last) begin
                  state_n = IDLE;
                  r_n     = 4'd0;
                  vld_n   = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  r_n = round_idx + 4'(UNROLL);
               end
            end
         end
         default: begin
            state_n = IDLE;
            r_n     = 4'd0;
            vld_n   = 1'b0;
         end
      endcase
      last_n = vld_n && (({1'b0, r_n} + 5'(UNROLL)) == {1'b0, ROUNDS_MAX});
   end

   // lane k carries the constant of round r+k; zero whenever not valid
   genvar k;
   generate
      for (k = 0; k < UNROLL; k++) begin : g_lane
         assign rc_n[8*k +: 8] = vld_n ? rc_of(4'(r_n + 4'(k))) : 8'h00;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rc        <= '0;
         rc_valid  <= 1'b0;
         last      <= 1'b0;
         round_idx <= 4'd0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         rc        <= rc_n;
         rc_valid  <= vld_n;
         last      <= last_n;
         round_idx <= r_n;
         done      <= done_n;
         err       <= err_n;
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_ascon_rc_seq.sv
// Directed bench for ascon_rc_seq with UNROLL=1 and UNROLL=2 instances
// sharing one set of inputs.
module tb_ascon_rc_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       advance = 1'b0;
   logic       abort = 1'b0;

   logic [7:0]  rc1;
   logic        vld1, last1, busy1, done1, err1;
   logic [3:0]  idx1;
   logic [15:0] rc2;
   logic        vld2, last2, busy2, done2, err2;
   logic [3:0]  idx2;

   int passed = 0;
   int total  = 0;

   logic [7:0] tab [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                            8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

   ascon_rc_seq #(.UNROLL(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
      .advance(advance), .abort(abort), .rc(rc1), .rc_valid(vld1),
      .last(last1), .round_idx(idx1), .busy(busy1), .done(done1), .err(err1));

   ascon_rc_seq #(.UNROLL(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
      .advance(advance), .abort(abort), .rc(rc2), .rc_valid(vld2),
      .last(last2), .round_idx(idx2), .busy(busy2), .done(done2), .err(err2));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      start = 1'b0; advance = 1'b0; abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if ({rc1, vld1, last1, idx1, busy1, done1, err1} !== 19'd0)
         $display("FAIL reset_u1: got %h expected 0", {rc1, vld1, last1, idx1, busy1, done1, err1});
      else passed++;
      total++;
      if ({rc2, vld2, last2, idx2, busy2, done2, err2} !== 27'd0)
         $display("FAIL reset_u2: got %h expected 0", {rc2, vld2, last2, idx2, busy2, done2, err2});
      else passed++;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_pa12();
      go_idle();
      start = 1'b1; mode = 2'b00;
      tick();
      start = 1'b0; advance = 1'b1;
      for (int i = 0; i < 12; i++) begin
         total++;
         if (rc1 !== tab[i] || vld1 !== 1'b1 || busy1 !== 1'b1 || idx1 !== 4'(i) || last1 !== (i == 11))
            $display("FAIL pa12_word%0d: got rc=%h v=%b b=%b idx=%0d last=%b expected rc=%h idx=%0d last=%b",
                     i, rc1, vld1, busy1, idx1, last1, tab[i], i, (i == 11));
         else passed++;
         tick();
      end
      advance = 1'b0;
      total++;
      if (done1 !== 1'b1 || vld1 !== 1'b0 || busy1 !== 1'b0 || rc1 !== 8'h00 || last1 !== 1'b0)
         $display("FAIL pa12_done: got done=%b v=%b b=%b rc=%h expected done=1 v=0 b=0 rc=00", done1, vld1, busy1, rc1);
      else passed++;
      tick();
      total++;
      if (done1 !== 1'b0) $display("FAIL pa12_done_pulse: got %b expected 0", done1);
      else passed++;
   endtask

   task automatic test_pb8();
      go_idle();
      start = 1'b1; mode = 2'b01;
      tick();
      start = 1'b0;
      total++;
      if (rc1 !== 8'hB4 || idx1 !== 4'd4) $display("FAIL pb8_first: got rc=%h idx=%0d expected B4 idx=4", rc1, idx1);
      else passed++;
      advance = 1'b1;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (rc1 !== tab[4+i] || last1 !== (i == 7))
            $display("FAIL pb8_word%0d: got rc=%h last=%b expected rc=%h last=%b", i, rc1, last1, tab[4+i], (i == 7));
         else passed++;
         tick();
      end
      advance = 1'b0;
      total++;
      if (done1 !== 1'b1 || vld1 !== 1'b0) $display("FAIL pb8_done: got done=%b v=%b expected 1 0", done1, vld1);
      else passed++;
   endtask

   task automatic test_unroll2();
      logic [15:0] e6 [3]  = '{16'h8796, 16'h6978, 16'h4B5A};
      logic [15:0] e12 [6] = '{16'hE1F0, 16'hC3D2, 16'hA5B4, 16'h8796, 16'h6978, 16'h4B5A};
      go_idle();
      start = 1'b1; mode = 2'b10;
      tick();
      start = 1'b0; advance = 1'b1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (rc2 !== e6[i] || last2 !== (i == 2) || idx2 !== 4'(6 + 2*i))
            $display("FAIL u2_pb6_word%0d: got rc=%h last=%b idx=%0d expected rc=%h last=%b idx=%0d",
                     i, rc2, last2, idx2, e6[i], (i == 2), 6 + 2*i);
         else passed++;
         tick();
      end
      // restart in the done cycle
      advance = 1'b0; start = 1'b1; mode = 2'b00;
      total++;
      if (done2 !== 1'b1 || vld2 !== 1'b0) $display("FAIL u2_pb6_done: got done=%b v=%b expected 1 0", done2, vld2);
      else passed++;
      tick();
      start = 1'b0; advance = 1'b1;
      for (int i = 0; i < 6; i++) begin
         total++;
         if (rc2 !== e12[i] || last2 !== (i == 5))
            $display("FAIL u2_pa12_word%0d: got rc=%h last=%b expected rc=%h last=%b", i, rc2, last2, e12[i], (i == 5));
         else passed++;
         tick();
      end
      advance = 1'b0;
      total++;
      if (done2 !== 1'b1) $display("FAIL u2_pa12_done: got %b expected 1", done2);
      else passed++;
   endtask

   task automatic test_illegal();
      go_idle();
      start = 1'b1; mode = 2'b11;
      tick();
      start = 1'b0;
      total++;
      if (err1 !== 1'b1 || busy1 !== 1'b0 || vld1 !== 1'b0)
         $display("FAIL illegal_err: got err=%b b=%b v=%b expected 1 0 0", err1, busy1, vld1);
      else passed++;
      tick();
      total++;
      if (err1 !== 1'b0 || busy1 !== 1'b0 || vld1 !== 1'b0)
         $display("FAIL illegal_after: got err=%b b=%b v=%b expected 0 0 0", err1, busy1, vld1);
      else passed++;
      start = 1'b1; mode = 2'b00;
      tick();
      start = 1'b0;
      total++;
      if (rc1 !== 8'hF0 || busy1 !== 1'b1 || err1 !== 1'b0)
         $display("FAIL illegal_recover: got rc=%h b=%b err=%b expected F0 1 0", rc1, busy1, err1);
      else passed++;
   endtask

   task automatic test_hold_abort();
      go_idle();
      start = 1'b1; mode = 2'b00;
      tick();
      start = 1'b0; advance = 1'b1;
      tick(); tick();
      advance = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (rc1 !== 8'hD2 || idx1 !== 4'd2 || vld1 !== 1'b1)
            $display("FAIL hold_cycle%0d: got rc=%h idx=%0d v=%b expected D2 2 1", i, rc1, idx1, vld1);
         else passed++;
      end
      abort = 1'b1; advance = 1'b1;
      tick();
      abort = 1'b0; advance = 1'b0;
      total++;
      if (rc1 !== 8'h00 || vld1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0 || idx1 !== 4'd0)
         $display("FAIL abort_clear: got rc=%h v=%b b=%b done=%b idx=%0d expected all 0", rc1, vld1, busy1, done1, idx1);
      else passed++;
      // abort on the final word must suppress done
      start = 1'b1; mode = 2'b01;
      tick();
      start = 1'b0; advance = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      total++;
      if (last1 !== 1'b1 || rc1 !== 8'h4B) $display("FAIL abort_last_pre: got last=%b rc=%h expected 1 4B", last1, rc1);
      else passed++;
      abort = 1'b1;
      tick();
      abort = 1'b0; advance = 1'b0;
      total++;
      if (done1 !== 1'b0 || busy1 !== 1'b0 || vld1 !== 1'b0)
         $display("FAIL abort_last: got done=%b b=%b v=%b expected 0 0 0", done1, busy1, vld1);
      else passed++;
      // start while busy is ignored, advance still processed
      start = 1'b1; mode = 2'b00;
      tick();
      mode = 2'b10; advance = 1'b1;
      tick();
      total++;
      if (rc1 !== 8'hE1 || idx1 !== 4'd1 || err1 !== 1'b0)
         $display("FAIL busy_start: got rc=%h idx=%0d err=%b expected E1 1 0", rc1, idx1, err1);
      else passed++;
      mode = 2'b11; advance = 1'b0;
      tick();
      start = 1'b0;
      total++;
      if (rc1 !== 8'hE1 || err1 !== 1'b0 || busy1 !== 1'b1)
         $display("FAIL busy_start_illegal: got rc=%h err=%b b=%b expected E1 0 1", rc1, err1, busy1);
      else passed++;
   endtask

   task automatic test_async_reset();
      go_idle();
      start = 1'b1; mode = 2'b00;
      tick();
      start = 1'b0; advance = 1'b1;
      tick(); tick();
      advance = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({rc1, vld1, last1, idx1, busy1, done1, err1} !== 19'd0)
         $display("FAIL async_reset: got %h expected 0", {rc1, vld1, last1, idx1, busy1, done1, err1});
      else passed++;
      tick();
      rst_n = 1'b1;
      tick();
      total++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) $display("FAIL reset_no_done: got done=%b b=%b expected 0 0", done1, busy1);
      else passed++;
      start = 1'b1; mode = 2'b00;
      tick();
      start = 1'b0;
      total++;
      if (rc1 !== 8'hF0 || vld1 !== 1'b1) $display("FAIL reset_restart: got rc=%h v=%b expected F0 1", rc1, vld1);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_pa12();
      test_pb8();
      test_unroll2();
      test_illegal();
      test_hold_abort();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
